// File: rtl/mux_stream_pkg.sv
// Shared encodings and widths for the round-robin stream multiplexer.
package mux_stream_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int unsigned XFER_CNT_W = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin search: first asserted request at or above ptr, wrapping from N-1 to 0.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] index,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IDX_W'((32'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any         = 1'b1;
        index       = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_stream.sv
// N-to-1 stream mux with fixed or round-robin selection into a one-entry output register.
// Define MUX_RR_STREAM_CNT_EN to add the 16-bit out-transfer counter port xfer_cnt.
module mux_rr_stream
  import mux_stream_pkg::*;
#(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned CHAN_W  = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [CHAN_W-1:0]         sel,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [CHAN_W-1:0]         out_chan,
`ifdef MUX_RR_STREAM_CNT_EN
  output logic [XFER_CNT_W-1:0]     xfer_cnt,
`endif
  input  logic                      out_ready
);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [CHAN_W-1:0]   chan_q, chan_d;
  logic [CHAN_W-1:0]   ptr_q, ptr_d;

  logic [CHANNELS-1:0] rr_grant;
  logic [CHAN_W-1:0]   rr_idx;
  logic                rr_any;

  logic [CHANNELS-1:0] fixed_vec;
  logic [CHANNELS-1:0] grant_vec;
  logic [CHAN_W-1:0]   grant_idx;
  logic                can_load;
  logic                load;
  logic                xfer_out;

  rr_arbiter #(
    .N     (CHANNELS),
    .IDX_W (CHAN_W)
  ) u_rr_arbiter (
    .req   (in_valid),
    .ptr   (ptr_q),
    .grant (rr_grant),
    .index (rr_idx),
    .any   (rr_any)
  );

  // Grant selection and handshake; a full register can reload only while it drains.
  always_comb begin
    fixed_vec = '0;
    if ((32'(sel) < CHANNELS) && in_valid[sel]) begin
      fixed_vec[sel] = 1'b1;
    end
    grant_vec = (mode == MODE_RR) ? rr_grant : fixed_vec;
    grant_idx = (mode == MODE_RR) ? rr_idx : sel;
    can_load  = (state_q == ST_EMPTY) || out_ready;
    in_ready  = (!rst && can_load) ? grant_vec : '0;
    load      = |in_ready;
    xfer_out  = (state_q == ST_FULL) && out_ready;
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    chan_d  = chan_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_EMPTY: if (load) state_d = ST_FULL;
      ST_FULL:  if (xfer_out && !load) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (load) begin
      chan_d = grant_idx;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (in_ready[i]) data_d = in_data[i*WIDTH +: WIDTH];
      end
      if (mode == MODE_RR) begin
        ptr_d = (32'(grant_idx) == CHANNELS - 1) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      chan_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_chan  = chan_q;

`ifdef MUX_RR_STREAM_CNT_EN
  logic [XFER_CNT_W-1:0] cnt_q, cnt_d;

  // Wraps naturally at 0xFFFF.
  always_comb begin
    cnt_d = cnt_q;
    if (xfer_out) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mux_rr_stream.sv
// Self-checking bench for mux_rr_stream: directed scenarios plus random traffic against a queue-free behavioural model.
module tb_mux_rr_stream;

  localparam int unsigned W  = 3;
  localparam int unsigned CH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mode = 1'b0;
  logic [1:0]    sel = '0;
  logic [CH-1:0] in_valid = '0;
  logic [CH*W-1:0] in_data = '0;
  logic [CH-1:0] in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [1:0]    out_chan;
  logic          out_ready = 1'b0;
`ifdef MUX_RR_STREAM_CNT_EN
  logic [15:0]   xfer_cnt;
`endif

  int compared = 0;
  int mismatched = 0;

  // Reference state: what the output register should hold, and the round-robin pointer.
  bit m_full;
  bit m_clean;
  int m_data;
  int m_chan;
  int m_ptr;
  int m_cnt;
  int m_total;

  mux_rr_stream dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_chan  (out_chan),
`ifdef MUX_RR_STREAM_CNT_EN
    .xfer_cnt  (xfer_cnt),
`endif
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check outputs against the model, then advance the model at the edge.
  task automatic cycle(input bit r, input bit md, input int s, input bit [CH-1:0] v,
                       input bit [CH*W-1:0] d, input bit ordy);
    int g;
    bit [CH-1:0] exp_rdy;
    @(negedge clk);
    rst = r; mode = md; sel = 2'(s); in_valid = v; in_data = d; out_ready = ordy;
    #1;
    g = -1;
    if (!r && (!m_full || ordy)) begin
      if (!md) begin
        if (s < CH && v[s]) g = s;
      end else begin
        for (int k = 0; k < CH; k++) begin
          if (g < 0 && v[(m_ptr + k) % CH]) g = (m_ptr + k) % CH;
        end
      end
    end
    exp_rdy = (g >= 0) ? CH'(1 << g) : '0;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(m_full));
    if (m_full || m_clean) begin
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("out_chan", 32'(out_chan), 32'(m_chan));
    end
`ifdef MUX_RR_STREAM_CNT_EN
    chk("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
`endif
    @(posedge clk);
    if (r) begin
      m_full = 0; m_clean = 1; m_data = 0; m_chan = 0; m_ptr = 0; m_cnt = 0;
    end else begin
      if (m_full && ordy) begin
        m_cnt = (m_cnt + 1) % 65536;
        m_total++;
      end
      if (g >= 0) begin
        m_data  = int'((d >> (g * W)) & 7);
        m_chan  = g;
        m_full  = 1;
        m_clean = 0;
        if (md) m_ptr = (g + 1) % CH;
      end else if (m_full && ordy) begin
        m_full = 0;
      end
    end
  endtask

  initial begin
    m_full = 0; m_clean = 0; m_data = 0; m_chan = 0; m_ptr = 0; m_cnt = 0; m_total = 0;

    // Reset state.
    cycle(1, 0, 0, 4'b0000, '0, 1);
    cycle(1, 0, 0, 4'b0000, '0, 1);
    cycle(0, 0, 0, 4'b0000, '0, 1);

    // Fixed select of lane 2 carrying 3'b101.
    cycle(0, 0, 2, 4'b0100, 12'b000_101_000_000, 1);
    cycle(0, 0, 2, 4'b0000, '0, 1);
    cycle(0, 0, 2, 4'b0000, '0, 1);

    // Round-robin with all channels valid: 0,1,2,3,0,...
    cycle(1, 1, 0, 4'b0000, '0, 1);
    for (int i = 0; i < 7; i++) cycle(0, 1, 0, 4'b1111, 12'($urandom), 1);

    // Pointer at 3 with only lanes 0/1 valid wraps to 0, then moves to 1.
    cycle(1, 1, 0, 4'b0000, '0, 1);
    cycle(0, 1, 0, 4'b0100, 12'($urandom), 1);
    cycle(0, 1, 0, 4'b0011, 12'($urandom), 1);
    cycle(0, 1, 0, 4'b0011, 12'($urandom), 1);
    cycle(0, 1, 0, 4'b0000, '0, 1);

    // Backpressure for three cycles, then reload on release.
    cycle(0, 0, 1, 4'b0010, 12'b000_000_110_000, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 4'b1111, 12'($urandom), 0);
    cycle(0, 0, 0, 4'b0001, 12'b000_000_000_011, 1);
    cycle(0, 0, 0, 4'b0000, '0, 0);

    // Out-of-range-free select change mid-stream, then reset while full.
    cycle(0, 1, 3, 4'b1000, 12'($urandom), 1);
    cycle(1, 0, 3, 4'b1111, 12'($urandom), 0);
    cycle(0, 0, 0, 4'b0000, '0, 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 99) < 2), 1'($urandom), int'($urandom_range(0, 3)),
            4'($urandom), 12'($urandom), ($urandom_range(0, 3) != 0));
    end

`ifdef MUX_RR_STREAM_CNT_EN
    // Counter wrap: 65537 transfers leave the count at 1.
    cycle(1, 1, 0, 4'b0000, '0, 1);
    m_total = 0;
    for (int i = 0; i < 70000 && m_total < 65537; i++) begin
      cycle(0, 1, 0, 4'b1111, 12'($urandom), 1);
    end
    cycle(0, 1, 0, 4'b0000, '0, 0);
    chk("xfer_cnt_wrap", 32'(xfer_cnt), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mux_rr_stream.md
MUX_RR_STREAM -- requirements
Module: mux_rr_stream

Interface
REQ-001 Parameter WIDTH, default 3, data bits per channel.
REQ-002 Parameter CHANNELS, default 4, number of input channels (range 2..16).
REQ-003 Parameter CHAN_W, default $clog2(CHANNELS), channel-index width; derived, never overridden.
REQ-004 Port clk  input  1  rising-edge clock for all state.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port mode  input  1  0 = fixed select via sel; 1 = round-robin over valid channels.
REQ-007 Port sel  input  CHAN_W  channel index used when mode=0.
REQ-008 Port in_valid  input  CHANNELS  per-channel data-valid.
REQ-009 Port in_data  input  CHANNELS*WIDTH  packed data; channel i at bits [i*WIDTH +: WIDTH].
REQ-010 Port in_ready  output  CHANNELS  per-channel accept, one-hot or zero.
REQ-011 Port out_valid  output  1  output register holds a word.
REQ-012 Port out_data  output  WIDTH  registered selected word.
REQ-013 Port out_chan  output  CHAN_W  source channel of out_data.
REQ-014 Port out_ready  input  1  downstream accept.

Function
REQ-015 The block SHALL hold a one-entry output register with states EMPTY and FULL; out_valid=1 exactly in FULL.
REQ-016 A transfer on channel i SHALL occur when in_valid[i] && in_ready[i]; a transfer out SHALL occur when out_valid && out_ready.
REQ-017 Grant SHALL be possible when state is EMPTY or out_ready=1 (load-while-unload, full throughput, one word per cycle).
REQ-018 mode=0: grant SHALL go to channel sel only if in_valid[sel]=1; sel >= CHANNELS SHALL grant nothing.
REQ-019 mode=1: grant SHALL go to the first valid channel at or after pointer ptr, searching upward with wrap from CHANNELS-1 to 0.
REQ-020 On a granted transfer in mode=1, ptr SHALL become (granted+1) mod CHANNELS; otherwise ptr SHALL hold; ptr SHALL not change in mode=0.
REQ-021 in_ready SHALL be combinational from in_valid, mode, sel, ptr, state and out_ready, and SHALL assert only for the granted channel.
REQ-022 Latency: data accepted in cycle n SHALL appear on out_data/out_chan in cycle n+1.
REQ-023 Transitions: EMPTY->FULL on grant; FULL->EMPTY on out transfer without grant; FULL->FULL on out transfer with grant (new word loaded) or when out_ready=0.
REQ-024 While FULL and out_ready=0, out_data/out_chan SHALL remain stable and all in_ready SHALL be 0.
REQ-025 Changing mode or sel mid-stream SHALL affect only the next grant, never the held word.

Reset
REQ-026 With rst=1 at a rising edge: state EMPTY, out_valid=0, out_data=0, out_chan=0, ptr=0.
REQ-027 in_ready SHALL be all zero while rst=1; a held word SHALL be discarded by reset.

Configuration
REQ-028 Macro MUX_RR_STREAM_CNT_EN, when defined, SHALL add output port xfer_cnt (16 bits) counting out transfers, reset to 0, wrapping 0xFFFF->0.
REQ-029 Without MUX_RR_STREAM_CNT_EN, xfer_cnt SHALL not exist and no counter logic SHALL be generated.

Structure
REQ-030 Package mux_stream_pkg SHALL hold mode encodings (MODE_FIXED=0, MODE_RR=1), state encodings (ST_EMPTY, ST_FULL) and the xfer_cnt width constant 16.
REQ-031 Round-robin search SHALL live in sub-module rr_arbiter (inputs req, ptr; outputs one-hot grant, index, any).

Verification
REQ-032 Defaults, mode=0, sel=2, in_valid=4'b0100, lane2=3'b101, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=3'b101, out_chan=2.
REQ-033 mode=1, all four valid continuously, out_ready=1 after reset -> out_chan sequence 0,1,2,3,0 on consecutive cycles.
REQ-034 mode=1, ptr=3, in_valid=4'b0011 -> grant channel 0 (wrap), then ptr=1.
REQ-035 FULL with out_ready=0 for 3 cycles -> out_data stable, in_ready=0; out_ready=1 on cycle 4 -> new word loaded same cycle, out_valid stays 1.
REQ-036 rst=1 asserted while FULL -> next cycle out_valid=0, out_data=0, ptr=0, xfer_cnt=0 (macro defined).
REQ-037 With MUX_RR_STREAM_CNT_EN, 65537 out transfers -> xfer_cnt=1.
